// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 single-precision divider (q = N1 / N2), truncating,
// subnormals flushed to zero; restoring mantissa divider, one quotient bit per clock.
module fp_div #(
  parameter int MANT_W = 23,
  parameter int QBITS  = 25
) (
  input  logic        CLOCK_50,
  input  logic        restart,
  input  logic        start,
  input  logic [31:0] N1,
  input  logic [31:0] N2,
  output logic [31:0] q,
  output logic        done,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for start, operands captured on the request edge
  // ITER  | one restoring-division step per clock, QBITS steps
  // NORM  | normalise quotient, build exponent, resolve special cases
  // DONE  | result held until start drops
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int RW = MANT_W + 3;
  localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [RW-1:0]     r_q, r_d;
  logic [RW-1:0]     dvs_q, dvs_d;
  logic [QBITS-1:0]  qacc_q, qacc_d;
  logic              sign_q, sign_d;
  logic [7:0]        e1_q, e1_d;
  logic [7:0]        e2_q, e2_d;
  logic [31:0]       q_q, q_d;
  logic              done_q, done_d;

  logic [RW-1:0]     r_sub;
  logic              r_ge;
  logic signed [9:0] e_norm;
  logic [MANT_W-1:0] frac;
  logic [31:0]       q_norm;

  always_comb begin
    r_sub  = r_q - dvs_q;
    r_ge   = (r_q >= dvs_q);
    // leading quotient bit decides between the two normalisation offsets
    e_norm = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q})
             + (qacc_q[QBITS-1] ? 10'sd127 : 10'sd126);
    frac   = qacc_q[QBITS-1] ? qacc_q[QBITS-2:1] : qacc_q[QBITS-3:0];

    if (e1_q == 8'hFF || e2_q == 8'hFF) begin
      q_norm = QNAN;
    end else if (e1_q == 8'h00 && e2_q == 8'h00) begin
      q_norm = QNAN;
    end else if (e2_q == 8'h00) begin
      q_norm = {sign_q, 8'hFF, 23'h0};
    end else if (e1_q == 8'h00) begin
      q_norm = {sign_q, 31'h0};
    end else if (e_norm >= 10'sd255) begin
      q_norm = {sign_q, 8'hFF, 23'h0};
    end else if (e_norm <= 10'sd0) begin
      q_norm = {sign_q, 31'h0};
    end else begin
      q_norm = {sign_q, e_norm[7:0], frac};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    sign_d  = sign_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    q_d     = q_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = N1[31] ^ N2[31];
          e1_d    = N1[30:23];
          e2_d    = N2[30:23];
          r_d     = {2'b01, N1[MANT_W-1:0]};
          dvs_d   = {2'b01, N2[MANT_W-1:0]};
          qacc_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        r_d    = r_ge ? (r_sub << 1) : (r_q << 1);
        qacc_d = {qacc_q[QBITS-2:0], r_ge};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        q_d     = q_norm;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (restart) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      sign_q  <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      sign_q  <= sign_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign done = done_q;
  assign busy = (state_q == S_ITER) || (state_q == S_NORM);

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: scoreboard of model results, latency,
// handshake, restart abort and operand-isolation scenarios.
module tb_fp_div;

  logic        CLOCK_50 = 1'b0;
  logic        restart;
  logic        start;
  logic [31:0] N1, N2;
  logic [31:0] q;
  logic        done, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fp_div dut (
    .CLOCK_50 (CLOCK_50),
    .restart  (restart),
    .start    (start),
    .N1       (N1),
    .N2       (N2),
    .q        (q),
    .done     (done),
    .busy     (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // reference: integer long division of the significands, then specials
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  e1, e2;
    logic        s;
    logic [47:0] num, den, quo;
    logic [22:0] fr;
    int          e;
    e1  = a[30:23];
    e2  = b[30:23];
    s   = a[31] ^ b[31];
    num = {24'd0, 1'b1, a[22:0]} << 24;
    den = {24'd0, 1'b1, b[22:0]};
    quo = num / den;
    if (quo[24]) begin
      fr = quo[23:1];
      e  = int'(e1) - int'(e2) + 127;
    end else begin
      fr = quo[22:0];
      e  = int'(e1) - int'(e2) + 126;
    end
    if (e1 == 8'hFF || e2 == 8'hFF) return 32'h7FC00000;
    if (e1 == 8'h00 && e2 == 8'h00) return 32'h7FC00000;
    if (e2 == 8'h00) return {s, 8'hFF, 23'h0};
    if (e1 == 8'h00) return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], fr};
  endfunction

  // Issues one request from IDLE, pushes the model result, waits (bounded) for done.
  // start is left high on return.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit glitch,
                        output logic [31:0] res, output int lat,
                        output logic busy0, output logic busy_end, output bit timeout);
    N1 = a;
    N2 = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge CLOCK_50); #1;
    busy0   = busy;
    lat     = 0;
    timeout = 1'b0;
    forever begin
      @(posedge CLOCK_50); #1;
      lat++;
      if (glitch && lat == 3) begin
        N1 = ~a;
        N2 = $urandom;
      end
      if (done) break;
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
    end
    res      = q;
    busy_end = busy;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset();
    restart = 1'b1;
    start   = 1'b0;
    N1      = 32'h0;
    N2      = 32'h0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (q !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: q=%h done=%b busy=%b, required q=0 done=0 busy=0", q, done, busy);
    end
    restart = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] va[9], vb[9], vq[9];
    logic [31:0] res, exp;
    int lat;
    logic b0, be;
    bit to;
    va = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'h3F800000, 32'h80000000,
           32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h00000000, 32'h00000000,
           32'hBF800000, 32'h3F800000, 32'h3E800000, 32'h47000000};
    vq = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000, 32'h7FC00000,
           32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], 1'b0, res, lat, b0, be, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++;
      if (to) begin
        n_err++;
        $display("FAIL vec%0d_timeout: no done after %0d edges, required 26", i, lat);
      end
      n_cmp++;
      if (lat !== 26) begin
        n_err++;
        $display("FAIL vec%0d_latency: %0d edges, required 26", i, lat);
      end
      n_cmp++;
      if (res !== exp) begin
        n_err++;
        $display("FAIL vec%0d_model: q=%h, required %h", i, res, exp);
      end
      n_cmp++;
      if (res !== vq[i]) begin
        n_err++;
        $display("FAIL vec%0d_const: q=%h, required %h", i, res, vq[i]);
      end
      n_cmp++;
      if (b0 !== 1'b1 || be !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d_busy: busy after capture=%b at done=%b, required 1/0", i, b0, be);
      end
      drop_start();
      n_cmp++;
      if (done !== 1'b0 || q !== vq[i]) begin
        n_err++;
        $display("FAIL vec%0d_drop: done=%b q=%h, required done=0 q=%h", i, done, q, vq[i]);
      end
    end
  endtask

  task automatic test_restart_mid();
    logic [31:0] res, exp;
    int lat;
    logic b0, be;
    bit to;
    N1 = 32'h3F800000;
    N2 = 32'h40400000;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    repeat (10) @(posedge CLOCK_50);
    #1;
    restart = 1'b1;
    start   = 1'b0;
    @(posedge CLOCK_50); #1;
    restart = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || q !== 32'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL restart_mid: done=%b q=%h busy=%b, required 0/0/0", done, q, busy);
    end
    run_op(32'h40C00000, 32'h40000000, 1'b0, res, lat, b0, be, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    n_cmp++;
    if (to || lat !== 26 || res !== exp || res !== 32'h40400000) begin
      n_err++;
      $display("FAIL restart_rerun: q=%h lat=%0d timeout=%0b, required q=40400000 lat=26", res, lat, to);
    end
    drop_start();
  endtask

  task automatic test_hold_and_isolation();
    logic [31:0] res, exp;
    int lat;
    logic b0, be;
    bit to;
    run_op(32'hC0F00000, 32'h40200000, 1'b1, res, lat, b0, be, to);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    n_cmp++;
    if (to || res !== exp || res !== 32'hC0400000) begin
      n_err++;
      $display("FAIL isolation: q=%h timeout=%0b, required C0400000", res, to);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge CLOCK_50); #1;
      n_cmp++;
      if (done !== 1'b1 || q !== 32'hC0400000) begin
        n_err++;
        $display("FAIL hold_c%0d: done=%b q=%h, required done=1 q=C0400000", c, done, q);
      end
    end
    drop_start();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL hold_drop: done=%b, required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, exp, a, b;
    int lat;
    logic b0, be;
    bit to;
    for (int i = 0; i < 14; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 0) begin
        a[30:23] = 8'(100 + $urandom_range(0, 50));
        b[30:23] = 8'(100 + $urandom_range(0, 50));
      end
      run_op(a, b, 1'b0, res, lat, b0, be, to);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      n_cmp++;
      if (to || lat !== 26 || res !== exp) begin
        n_err++;
        $display("FAIL b2b%0d: %h/%h q=%h lat=%0d, required q=%h lat=26", i, a, b, res, lat, exp);
      end
      drop_start();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_restart_mid();
    test_hold_and_isolation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
